// File: rtl/mem_pkg.sv
// Shared constants and FSM state type for the burst memory initiator.
package mem_pkg;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned LEN_W     = 8;
  localparam int unsigned MEM_WORDS = 4096;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdData,
    StWr,
    StDone
  } mem_master_state_t;

endpackage

// File: rtl/mem_addr_gen.sv
// Burst address/count tracker: loads the first address and length, steps per beat.
module mem_addr_gen
  import mem_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      addr_q <= load_addr;
      cnt_q  <= load_len;
    end else if (step && (cnt_q != '0)) begin
      // Address wraps naturally modulo 2^ADDR_W.
      addr_q <= addr_q + 1'b1;
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/mem_master.sv
// Burst initiator for the 4K x 16 RAM: sequences memSrc/memDes/AR/CB per beat.
// Define MEM_MASTER_WRAP_EN to let bursts wrap past the top address instead of erroring.
module mem_master
  import mem_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  input  logic [DATA_W-1:0] memData,
  output logic              memSrc,
  output logic              memDes,
  output logic [ADDR_W-1:0] AR,
  output logic [DATA_W-1:0] CB
);

  mem_master_state_t state_q, state_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              ag_load, ag_step, last;
  logic [ADDR_W-1:0] addr_q;
  logic              overflow;

`ifdef MEM_MASTER_WRAP_EN
  assign overflow = 1'b0;
`else
  logic [ADDR_W:0] end_addr;
  assign end_addr = {1'b0, req_addr} + {{(ADDR_W + 1 - LEN_W){1'b0}}, req_len};
  assign overflow = (end_addr >= (ADDR_W + 1)'(MEM_WORDS));
`endif

  mem_addr_gen u_addr_gen (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .load      (ag_load),
    .step      (ag_step),
    .load_addr (req_addr),
    .load_len  (req_len),
    .addr      (addr_q),
    .last      (last)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      // RAM read is combinational on AR while memSrc is high.
      if (state_q == StRdIssue) rd_data_q <= memData;
    end
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    ag_load   = 1'b0;
    ag_step   = 1'b0;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    memSrc    = 1'b0;
    memDes    = 1'b0;
    AR        = addr_q;
    CB        = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          ag_load = 1'b1;
          err_d   = overflow;
          if (overflow)    state_d = StDone;
          else if (req_we) state_d = StWr;
          else             state_d = StRdIssue;
        end
      end
      StRdIssue: begin
        memSrc  = 1'b1;
        state_d = StRdData;
      end
      StRdData: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          if (last) begin
            state_d = StDone;
          end else begin
            ag_step = 1'b1;
            state_d = StRdIssue;
          end
        end
      end
      StWr: begin
        wr_ready = 1'b1;
        memDes   = wr_valid;
        CB       = wr_data;
        if (wr_valid) begin
          if (last) state_d = StDone;
          else      ag_step = 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        err     = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed self-checking bench for mem_master with a combinational-read RAM model.
// Expectations for the top-address burst follow MEM_MASTER_WRAP_EN.
module tb_mem_master;
  import mem_pkg::*;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              done, err;
  logic [DATA_W-1:0] memData;
  logic              memSrc, memDes;
  logic [ADDR_W-1:0] AR;
  logic [DATA_W-1:0] CB;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  mem_master dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .done      (done),
    .err       (err),
    .memData   (memData),
    .memSrc    (memSrc),
    .memDes    (memDes),
    .AR        (AR),
    .CB        (CB)
  );

  initial for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = '0;

  always @(posedge CLK) if (memDes) mem[AR] <= CB;
  assign memData = mem[AR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic request(input logic we, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_len   = l;
    tick();
    req_valid = 1'b0;
    #1;
  endtask

  initial begin
    RST_N = 1'b0; req_valid = 0; req_we = 0; req_addr = '0; req_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0;
    tick(); tick();
    chk("rst_memsrc", memSrc, 0);
    chk("rst_rdvalid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_ar", AR, 0);
    chk("rst_rddata", rd_data, 0);
    RST_N = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1);

    // Write 0x010 len 3, wr_valid held
    request(1'b1, 12'h010, 8'd3);
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 16'hA001 + 16'(i);
      #1;
      chk("wr_ready", wr_ready, 1);
      chk("wr_memdes", memDes, 1);
      chk("wr_ar", AR, 32'h010 + 32'(i));
      chk("wr_cb", CB, 32'hA001 + 32'(i));
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk("wr_done", done, 1);
    chk("wr_err", err, 0);
    chk("wr_done_memdes", memDes, 0);
    tick();
    chk("wr_idle_ready", req_ready, 1);
    chk("wr_done_drop", done, 0);

    // Read same burst, rd_ready held
    rd_ready = 1'b1;
    request(1'b0, 12'h010, 8'd3);
    for (int i = 0; i < 4; i++) begin
      chk("rd_memsrc", memSrc, 1);
      chk("rd_ar", AR, 32'h010 + 32'(i));
      chk("rd_issue_valid", rd_valid, 0);
      tick();
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, 32'hA001 + 32'(i));
      chk("rd_data_memsrc", memSrc, 0);
      tick();
    end
    chk("rd_done", done, 1);
    chk("rd_err", err, 0);
    tick();
    chk("rd_idle_ready", req_ready, 1);

    // Read 0x012 len 1 with back-pressure
    rd_ready = 1'b0;
    request(1'b0, 12'h012, 8'd1);
    chk("bp_memsrc", memSrc, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", rd_valid, 1);
      chk("bp_hold_data", rd_data, 16'hA003);
      chk("bp_no_memsrc", memSrc, 0);
      tick();
    end
    rd_ready = 1'b1;
    tick();
    chk("bp_second_memsrc", memSrc, 1);
    chk("bp_second_ar", AR, 12'h013);
    tick();
    chk("bp_second_data", rd_data, 16'hA004);
    tick();
    chk("bp_done", done, 1);
    tick();

    // Write near the top of memory
    request(1'b1, 12'hFFE, 8'd3);
`ifdef MEM_MASTER_WRAP_EN
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 16'hB001 + 16'(i);
      #1;
      chk("wrap_memdes", memDes, 1);
      chk("wrap_ar", AR, 32'((12'hFFE + 12'(i)) & 12'hFFF));
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk("wrap_done", done, 1);
    chk("wrap_err", err, 0);
    chk("wrap_mem_fff", mem[12'hFFF], 16'hB002);
    chk("wrap_mem_000", mem[12'h000], 16'hB003);
    tick();
`else
    chk("ovf_done", done, 1);
    chk("ovf_err", err, 1);
    chk("ovf_memdes", memDes, 0);
    chk("ovf_wr_ready", wr_ready, 0);
    tick();
    chk("ovf_idle_ready", req_ready, 1);
    chk("ovf_err_drop", err, 0);
    chk("ovf_mem_ffe", mem[12'hFFE], 16'h0000);
`endif

    // Burst ending exactly at 0xFFF is legal in both builds
    request(1'b1, 12'hFFF, 8'd0);
    wr_valid = 1'b1; wr_data = 16'h5A5A;
    #1;
    chk("top_memdes", memDes, 1);
    chk("top_ar", AR, 12'hFFF);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("top_done", done, 1);
    chk("top_err", err, 0);
    chk("top_mem", mem[12'hFFF], 16'h5A5A);
    tick();

    // Reset in the middle of a read burst
    rd_ready = 1'b1;
    request(1'b0, 12'h010, 8'd3);
    tick();
    chk("mid_rdvalid_pre", rd_valid, 1);
    RST_N = 1'b0;
    #1;
    chk("mid_memsrc", memSrc, 0);
    chk("mid_rdvalid", rd_valid, 0);
    chk("mid_done", done, 0);
    chk("mid_rddata", rd_data, 0);
    tick();
    RST_N = 1'b1;
    #1;
    chk("mid_req_ready", req_ready, 1);
    tick();
    chk("mid_no_done", done, 0);
    request(1'b1, 12'h020, 8'd0);
    wr_valid = 1'b1; wr_data = 16'hC0DE;
    tick();
    wr_valid = 1'b0;
    #1;
    chk("post_wr_done", done, 1);
    tick();
    request(1'b0, 12'h020, 8'd0);
    tick();
    chk("post_rd_data", rd_data, 16'hC0DE);
    tick();
    chk("post_rd_done", done, 1);
    tick();

    // Gapped write beats 1,0,0,1
    request(1'b1, 12'h030, 8'd1);
    wr_valid = 1'b1; wr_data = 16'hD001;
    #1;
    chk("gap_b0_memdes", memDes, 1);
    chk("gap_b0_ar", AR, 12'h030);
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("gap_idle_memdes", memDes, 0);
      chk("gap_idle_ar", AR, 12'h031);
      chk("gap_idle_wr_ready", wr_ready, 1);
      tick();
    end
    wr_valid = 1'b1; wr_data = 16'hD002;
    #1;
    chk("gap_b1_memdes", memDes, 1);
    chk("gap_b1_ar", AR, 12'h031);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("gap_done", done, 1);
    chk("gap_mem0", mem[12'h030], 16'hD001);
    chk("gap_mem1", mem[12'h031], 16'hD002);
    tick();
    chk("gap_idle_ready", req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
